seq_recombiner: RTL and testbench



---
 rtl/div_pkg.sv | 16 +
 rtl/seq_recombiner_if.sv | 25 ++
 rtl/seq_recombiner.sv | 106 ++++++++++
 tb/tb_seq_recombiner.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared divider/recombiner width, state type and product width helper
package div_pkg;

    localparam int DIV_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int prod_width(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/seq_recombiner_if.sv
// rtl/seq_recombiner_if.sv - request/result bundle between a requester and seq_recombiner
interface seq_recombiner_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic                         start;
    logic [WIDTH-1:0]             Quotient;
    logic [WIDTH-1:0]             B;
    logic [WIDTH-1:0]             Remainder;
    logic                         busy;
    logic                         done;
    logic [prod_width(WIDTH)-1:0] Product;
    logic                         invalid;

    modport master (
        output start, Quotient, B, Remainder,
        input  busy, done, Product, invalid
    );

    modport slave (
        input  start, Quotient, B, Remainder,
        output busy, done, Product, invalid
    );
endinterface

// File: rtl/seq_recombiner.sv
// rtl/seq_recombiner.sv - iterative shift-add rebuild of Product = Quotient*B + Remainder
// Optional macro REM_CHECK_EN: flags Remainder >= B alongside the result.
module seq_recombiner
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
)(
    input  logic             clk,
    input  logic             reset,
    seq_recombiner_if.slave  bus
);

    localparam int PW = prod_width(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);

    state_t          state;
    state_t          state_next;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   mcand;
    logic [PW-1:0]   acc_step;
    logic [PW-1:0]   product;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]   count;
    logic            last_step;

    assign acc_step  = mplier[0] ? (acc + mcand) : acc;
    assign last_step = (count == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Fixed WIDTH steps regardless of operand values, so latency never varies.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc    <= {{WIDTH{1'b0}}, bus.Remainder};
                        mcand  <= {{WIDTH{1'b0}}, bus.B};
                        mplier <= bus.Quotient;
                        count  <= '0;
                    end
                end
                RUN: begin
                    acc    <= acc_step;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CW'(1);
                    if (last_step) begin
                        product <= acc_step;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (state == RUN);
    assign bus.done    = (state == DONE);
    assign bus.Product = product;

`ifdef REM_CHECK_EN
    logic inv_pending;
    logic invalid_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inv_pending <= 1'b0;
            invalid_r   <= 1'b0;
        end else begin
            if (state == IDLE && bus.start) begin
                inv_pending <= (bus.Remainder >= bus.B);
            end
            if (state == RUN && last_step) begin
                invalid_r <= inv_pending;
            end
        end
    end

    assign bus.invalid = invalid_r;
`else
    assign bus.invalid = 1'b0;
`endif

endmodule

// File: tb/tb_seq_recombiner.sv
// tb/tb_seq_recombiner.sv - directed table-driven bench for seq_recombiner
module tb_seq_recombiner;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0]   q;
        logic [W-1:0]   b;
        logic [W-1:0]   r;
        logic [2*W-1:0] exp_p;
        logic           exp_inv;
    } vec_t;

    logic clk;
    logic reset;
    int   passed;
    int   total;

    seq_recombiner_if #(.WIDTH(W)) bus ();

    seq_recombiner #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic inv_exp(input logic v);
`ifdef REM_CHECK_EN
        return v;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic set_ops(input logic [W-1:0] q, input logic [W-1:0] b, input logic [W-1:0] r);
        bus.Quotient  = q;
        bus.B         = b;
        bus.Remainder = r;
    endtask

    task automatic run_op(input string name, input vec_t v);
        int busy_cnt;
        int early_done;
        busy_cnt   = 0;
        early_done = 0;
        @(negedge clk);
        set_ops(v.q, v.b, v.r);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (bus.busy) busy_cnt++;
            if (bus.done) early_done++;
            if (i < W - 1) @(negedge clk);
        end
        check({name, "_busy_cycles"}, busy_cnt, W);
        check({name, "_early_done"}, early_done, 0);
        @(negedge clk);
        check({name, "_done"}, {31'd0, bus.done}, 1);
        check({name, "_busy_at_done"}, {31'd0, bus.busy}, 0);
        check({name, "_product"}, {24'd0, bus.Product}, {24'd0, v.exp_p});
        check({name, "_invalid"}, {31'd0, bus.invalid}, {31'd0, inv_exp(v.exp_inv)});
        @(negedge clk);
        check({name, "_done_pulse"}, {31'd0, bus.done}, 0);
        check({name, "_product_hold"}, {24'd0, bus.Product}, {24'd0, v.exp_p});
    endtask

    initial begin
        vec_t vecs[6];
        vec_t v;
        int   act;
        int   done_cnt;
        int   done_at[3];

        vecs[0] = '{q: 4'd3,  b: 4'd4,  r: 4'd2,  exp_p: 8'd14,  exp_inv: 1'b0};
        vecs[1] = '{q: 4'd15, b: 4'd15, r: 4'd14, exp_p: 8'd239, exp_inv: 1'b0};
        vecs[2] = '{q: 4'd9,  b: 4'd0,  r: 4'd5,  exp_p: 8'd5,   exp_inv: 1'b1};
        vecs[3] = '{q: 4'd0,  b: 4'd7,  r: 4'd3,  exp_p: 8'd3,   exp_inv: 1'b0};
        vecs[4] = '{q: 4'd15, b: 4'd1,  r: 4'd0,  exp_p: 8'd15,  exp_inv: 1'b0};
        vecs[5] = '{q: 4'd6,  b: 4'd5,  r: 4'd5,  exp_p: 8'd35,  exp_inv: 1'b1};

        passed = 0;
        total  = 0;
        reset  = 1'b1;
        bus.start = 1'b0;
        set_ops('0, '0, '0);
        repeat (2) @(negedge clk);
        check("reset_busy", {31'd0, bus.busy}, 0);
        check("reset_done", {31'd0, bus.done}, 0);
        check("reset_product", {24'd0, bus.Product}, 0);
        check("reset_invalid", {31'd0, bus.invalid}, 0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i]);
        end

        // start held and operands changed during RUN must not affect result or re-trigger
        @(negedge clk);
        set_ops(4'd2, 4'd3, 4'd1);
        bus.start = 1'b1;
        @(negedge clk);
        set_ops(4'd7, 4'd7, 4'd0);
        repeat (W) @(negedge clk);
        check("ign_done", {31'd0, bus.done}, 1);
        check("ign_product", {24'd0, bus.Product}, 7);
        bus.start = 1'b0;
        act = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.busy || bus.done) act++;
        end
        check("ign_no_second_run", act, 0);
        check("ign_product_hold", {24'd0, bus.Product}, 7);

        // reset after two steps aborts immediately
        @(negedge clk);
        set_ops(4'd5, 4'd5, 4'd0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_busy", {31'd0, bus.busy}, 0);
        check("abort_done", {31'd0, bus.done}, 0);
        check("abort_product", {24'd0, bus.Product}, 0);
        @(negedge clk);
        reset = 1'b0;
        v = '{q: 4'd5, b: 4'd5, r: 4'd0, exp_p: 8'd25, exp_inv: 1'b0};
        run_op("after_abort", v);

        // back-to-back with start held high: one acceptance every W+2 cycles
        @(negedge clk);
        set_ops(4'd3, 4'd4, 4'd2);
        bus.start = 1'b1;
        done_cnt = 0;
        for (int n = 1; n <= 3 * (W + 2); n++) begin
            @(negedge clk);
            if (bus.done) begin
                if (done_cnt < 3) done_at[done_cnt] = n;
                case (done_cnt)
                    0: begin
                        check("b2b_product0", {24'd0, bus.Product}, 14);
                        set_ops(4'd15, 4'd15, 4'd14);
                    end
                    1: begin
                        check("b2b_product1", {24'd0, bus.Product}, 239);
                        set_ops(4'd6, 4'd5, 4'd5);
                    end
                    default: check("b2b_product2", {24'd0, bus.Product}, 35);
                endcase
                done_cnt++;
            end
        end
        bus.start = 1'b0;
        check("b2b_done_count", done_cnt, 3);
        if (done_cnt == 3) begin
            check("b2b_first_done", done_at[0], W + 1);
            check("b2b_gap0", done_at[1] - done_at[0], W + 2);
            check("b2b_gap1", done_at[2] - done_at[1], W + 2);
        end
        repeat (W + 3) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
